// File: rtl/round_incr_pipe.sv
// rtl/round_incr_pipe.sv - two-stage rounding (decide, increment) with valid/ready flow control
module round_incr_pipe #(
  parameter int NF = 52,
  parameter int NE = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          InValid,
  output logic          InReady,
  input  logic          Ms,
  input  logic [NF:0]   Mm,
  input  logic          G,
  input  logic          S,
  input  logic [NE-1:0] Me,
  input  logic [2:0]    Frm,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          Rs,
  output logic [NF:0]   Rm,
  output logic [NE:0]   Re,
  output logic          Inexact
);

  logic          v1_q, v1_d, v2_q, v2_d;
  logic          ms1_q, ms1_d, inx1_q, inx1_d, rup1_q, rup1_d;
  logic [NF:0]   mm1_q, mm1_d;
  logic [NE-1:0] me1_q, me1_d;
  logic          rs_q, rs_d, inx2_q, inx2_d;
  logic [NF:0]   rm_q, rm_d;
  logic [NE:0]   re_q, re_d;

  logic          load1, load2, round_up;
  logic [NF+1:0] sum;

  assign load2   = ~v2_q | OutReady;
  assign load1   = ~v1_q | load2;
  assign InReady = load1;

  // Unused encodings 101-111 fall back to round-to-nearest-even.
  always_comb begin
    round_up = G & (S | Mm[0]);
    case (Frm)
      3'b001:  round_up = 1'b0;
      3'b010:  round_up = Ms & (G | S);
      3'b011:  round_up = ~Ms & (G | S);
      3'b100:  round_up = G;
      default: round_up = G & (S | Mm[0]);
    endcase
  end

  always_comb begin
    v1_d   = v1_q;
    ms1_d  = ms1_q;
    mm1_d  = mm1_q;
    me1_d  = me1_q;
    inx1_d = inx1_q;
    rup1_d = rup1_q;
    if (flush) begin
      v1_d = 1'b0;
    end else if (load1) begin
      v1_d = InValid;
      if (InValid) begin
        ms1_d  = Ms;
        mm1_d  = Mm;
        me1_d  = Me;
        inx1_d = G | S;
        rup1_d = round_up;
      end
    end
  end

  assign sum = {1'b0, mm1_q} + {{(NF+1){1'b0}}, rup1_q};

  // A carry only happens from an all-ones mantissa, so the renormalised value is 1.000...
  always_comb begin
    v2_d   = v2_q;
    rs_d   = rs_q;
    rm_d   = rm_q;
    re_d   = re_q;
    inx2_d = inx2_q;
    if (flush) begin
      v2_d = 1'b0;
    end else if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        rs_d   = ms1_q;
        inx2_d = inx1_q;
        if (sum[NF+1]) begin
          rm_d = {1'b1, {NF{1'b0}}};
          re_d = {1'b0, me1_q} + {{NE{1'b0}}, 1'b1};
        end else begin
          rm_d = sum[NF:0];
          re_d = {1'b0, me1_q};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ms1_q  <= 1'b0;
      mm1_q  <= '0;
      me1_q  <= '0;
      inx1_q <= 1'b0;
      rup1_q <= 1'b0;
      rs_q   <= 1'b0;
      rm_q   <= '0;
      re_q   <= '0;
      inx2_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      ms1_q  <= ms1_d;
      mm1_q  <= mm1_d;
      me1_q  <= me1_d;
      inx1_q <= inx1_d;
      rup1_q <= rup1_d;
      rs_q   <= rs_d;
      rm_q   <= rm_d;
      re_q   <= re_d;
      inx2_q <= inx2_d;
    end
  end

  assign OutValid = v2_q;
  assign Rs       = rs_q;
  assign Rm       = rm_q;
  assign Re       = re_q;
  assign Inexact  = inx2_q;

endmodule

// File: tb/tb_round_incr_pipe.sv
// tb/tb_round_incr_pipe.sv - directed vectors for round_incr_pipe with NF=4, NE=5
module tb_round_incr_pipe;

  logic       clk = 1'b0;
  logic       reset_n, flush, InValid, InReady, Ms, G, S, OutValid, OutReady, Rs, Inexact;
  logic [4:0] Mm, Me, Rm;
  logic [2:0] Frm;
  logic [5:0] Re;

  int n_vec = 0;
  int n_mis = 0;

  round_incr_pipe #(.NF(4), .NE(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .InValid(InValid), .InReady(InReady),
    .Ms(Ms), .Mm(Mm), .G(G), .S(S), .Me(Me), .Frm(Frm),
    .OutValid(OutValid), .OutReady(OutReady),
    .Rs(Rs), .Rm(Rm), .Re(Re), .Inexact(Inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ms, input logic [4:0] mm, input logic g, input logic s,
                       input logic [4:0] me, input logic [2:0] frm);
    Ms = ms; Mm = mm; G = g; S = s; Me = me; Frm = frm;
  endtask

  // Single item through an empty pipe with OutReady held high.
  task automatic send_one(input string tag, input logic ms, input logic [4:0] mm,
                          input logic g, input logic s, input logic [4:0] me,
                          input logic [2:0] frm, input logic [4:0] e_rm,
                          input logic [5:0] e_re, input logic e_inx);
    @(negedge clk);
    OutReady = 1'b1;
    drive(ms, mm, g, s, me, frm);
    InValid = 1'b1;
    #1 check({tag, "_inready"}, 32'(InReady), 32'd1);
    @(negedge clk);
    InValid = 1'b0;
    #1 check({tag, "_early"}, 32'(OutValid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, 32'(OutValid), 32'd1);
    check({tag, "_rm"}, 32'(Rm), 32'(e_rm));
    check({tag, "_re"}, 32'(Re), 32'(e_re));
    check({tag, "_inx"}, 32'(Inexact), 32'(e_inx));
    check({tag, "_rs"}, 32'(Rs), 32'(ms));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov"}, 32'(OutValid), 32'd0);
    check({tag, "_rs"}, 32'(Rs), 32'd0);
    check({tag, "_rm"}, 32'(Rm), 32'd0);
    check({tag, "_re"}, 32'(Re), 32'd0);
    check({tag, "_inx"}, 32'(Inexact), 32'd0);
  endtask

  // Stall the output and load two items, leaving both stages full.
  task automatic fill_two();
    @(negedge clk);
    OutReady = 1'b0;
    drive(1'b1, 5'b10001, 1'b1, 1'b1, 5'd3, 3'b000);
    InValid = 1'b1;
    @(negedge clk);
    drive(1'b0, 5'b10011, 1'b0, 1'b0, 5'd4, 3'b000);
    @(negedge clk);
    drive(1'b1, 5'b11001, 1'b0, 1'b1, 5'd5, 3'b000);
    #1 check("fill_full_inready", 32'(InReady), 32'd0);
  endtask

  task automatic watch_empty(input string tag);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check({tag, "_no_out"}, 32'(OutValid), 32'd0);
    end
  endtask

  logic [4:0] bp_rm [5];
  int idx, out_idx, occ;
  logic acc, outx;

  initial begin
    reset_n = 1'b0; flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'b000);
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    reset_n = 1'b1;
    #1 check("reset_inready", 32'(InReady), 32'd1);

    send_one("rne_even",  1'b0, 5'b10110, 1'b1, 1'b0, 5'd7,  3'b000, 5'b10110, 6'd7,  1'b1);
    send_one("rne_odd",   1'b0, 5'b10111, 1'b1, 1'b0, 5'd7,  3'b000, 5'b11000, 6'd7,  1'b1);
    send_one("exact",     1'b0, 5'b10111, 1'b0, 1'b0, 5'd7,  3'b000, 5'b10111, 6'd7,  1'b0);
    send_one("carry",     1'b0, 5'b11111, 1'b0, 1'b1, 5'd7,  3'b011, 5'b10000, 6'd8,  1'b1);
    send_one("carry_ovf", 1'b0, 5'b11111, 1'b0, 1'b1, 5'd31, 3'b011, 5'b10000, 6'd32, 1'b1);
    send_one("rdn_neg",   1'b1, 5'b10100, 1'b0, 1'b1, 5'd9,  3'b010, 5'b10101, 6'd9,  1'b1);
    send_one("rdn_pos",   1'b0, 5'b10100, 1'b0, 1'b1, 5'd9,  3'b010, 5'b10100, 6'd9,  1'b1);
    send_one("rup_pos",   1'b0, 5'b10100, 1'b0, 1'b1, 5'd9,  3'b011, 5'b10101, 6'd9,  1'b1);
    send_one("rup_neg",   1'b1, 5'b10100, 1'b0, 1'b1, 5'd9,  3'b011, 5'b10100, 6'd9,  1'b1);
    send_one("rtz",       1'b0, 5'b10111, 1'b1, 1'b1, 5'd2,  3'b001, 5'b10111, 6'd2,  1'b1);
    send_one("f110_odd",  1'b0, 5'b10111, 1'b1, 1'b0, 5'd7,  3'b110, 5'b11000, 6'd7,  1'b1);
    send_one("f110_even", 1'b1, 5'b10110, 1'b1, 1'b0, 5'd7,  3'b110, 5'b10110, 6'd7,  1'b1);
    send_one("rmm",       1'b0, 5'b10110, 1'b1, 1'b0, 5'd6,  3'b100, 5'b10111, 6'd6,  1'b1);

    // Backpressure: item i is Mm=16+2i with G=S=1 under RNE, so Rm=17+2i, Re=i+1.
    for (int i = 0; i < 5; i++) bp_rm[i] = 5'(17 + 2 * i);
    idx = 0; out_idx = 0; occ = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      OutReady = !(cyc >= 2 && cyc <= 5);
      InValid = (idx < 5);
      if (idx < 5) drive(idx[0], 5'(16 + 2 * idx), 1'b1, 1'b1, 5'(idx + 1), 3'b000);
      #1;
      check("bp_inready", 32'(InReady), 32'((occ < 2) || OutReady));
      acc  = InValid && InReady;
      outx = OutValid && OutReady;
      if (OutValid) begin
        check("bp_rm", 32'(Rm), (out_idx < 5) ? 32'(bp_rm[out_idx]) : 32'hdead);
        check("bp_re", 32'(Re), 32'(out_idx + 1));
        check("bp_rs", 32'(Rs), 32'(out_idx % 2));
      end
      if (acc) idx++;
      if (outx) out_idx++;
      occ = occ + int'(acc) - int'(outx);
    end
    InValid = 1'b0;
    check("bp_in_count", 32'(idx), 32'd5);
    check("bp_out_count", 32'(out_idx), 32'd5);

    fill_two();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    #1 check("flush_ov", 32'(OutValid), 32'd0);
    watch_empty("flush");

    fill_two();
    reset_n = 1'b0;
    @(negedge clk);
    InValid = 1'b0; OutReady = 1'b1;
    #1 check_zero("midreset");
    reset_n = 1'b1;
    #1 check("midreset_inready", 32'(InReady), 32'd1);
    watch_empty("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
